// File: rtl/ir_pkg.sv
// ============================================================================
// Module  : ir_pkg
// Brief   : Shared widths, field typedefs and word-split helper for the
//           instruction prefetch queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ir_pkg;

    localparam int INSTR_W_DEF   = 18;
    localparam int OPCODE_W_DEF  = 6;
    localparam int OPERAND_W_DEF = 12;

    typedef logic [OPCODE_W_DEF-1:0]  opcode_t;
    typedef logic [OPERAND_W_DEF-1:0] operand_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W_DEF-1:0] word);
        instr_fields_t f;
        f.opcode  = word[INSTR_W_DEF-1 -: OPCODE_W_DEF];
        f.operand = word[OPERAND_W_DEF-1:0];
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ir_queue_ctrl.sv
// ============================================================================
// Module  : ir_queue_ctrl
// Brief   : Read/write pointer and occupancy tracking for the prefetch queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_queue_ctrl
    import ir_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_en,
    input  logic             consume,
    input  logic             flush,
    output logic             push_ok,
    output logic             pop_ok,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr_next,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [CNT_W-1:0] r_count;
    logic             r_full;

    // Explicit wrap keeps DEPTH=1 (1-bit pointer pinned at 0) correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) n = '0;
        else                        n = p + PTR_W'(1);
        return n;
    endfunction

    assign empty   = (r_count == '0);
    assign full    = r_full;
    assign pop_ok  = consume && !empty && !flush;
    assign push_ok = write_en && (!r_full || pop_ok) && !flush;

    always_comb begin
        rd_ptr_next   = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        count_next    = r_count;
        if (flush) begin
            rd_ptr_next   = '0;
            w_wr_ptr_next = '0;
            count_next    = '0;
        end else begin
            if (pop_ok)  rd_ptr_next   = ptr_inc(r_rd_ptr);
            if (push_ok) w_wr_ptr_next = ptr_inc(r_wr_ptr);
            if (push_ok && !pop_ok)      count_next = r_count + CNT_W'(1);
            else if (pop_ok && !push_ok) count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_rd_ptr <= rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= count_next;
            r_full   <= (count_next == CNT_W'(DEPTH));
        end
    end

    assign rd_ptr = r_rd_ptr;
    assign wr_ptr = r_wr_ptr;
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/ir_prefetch_queue.sv
// ============================================================================
// Module  : ir_prefetch_queue
// Brief   : DEPTH-entry instruction prefetch queue with registered head
//           opcode/operand outputs and in-place operand increment.
//           Optional: define IR_PARITY_EN for an even-parity bit on datain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int OPCODE_W  = OPCODE_W_DEF,
    parameter int OPERAND_W = OPERAND_W_DEF,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_en,
`ifdef IR_PARITY_EN
    input  logic [INSTR_W:0]             datain,
`else
    input  logic [INSTR_W-1:0]           datain,
`endif
    input  logic                         consume,
    input  logic                         inc_en,
    input  logic                         flush,
    output logic [OPERAND_W-1:0]         dataout,
    output logic [OPCODE_W-1:0]          instruction,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         par_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (OPCODE_W + OPERAND_W != INSTR_W) begin : g_width_check
        $error("ir_prefetch_queue: OPCODE_W + OPERAND_W must equal INSTR_W");
    end
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ir_prefetch_queue: DEPTH must be a power of two >= 1");
    end

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [PTR_W-1:0]     w_rd_ptr;
    logic [PTR_W-1:0]     w_wr_ptr;
    logic [PTR_W-1:0]     w_rd_ptr_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [INSTR_W-1:0]   w_data;
    logic                 w_inc;
    logic                 w_bypass;
    logic [INSTR_W-1:0]   w_head;
    logic [OPCODE_W-1:0]  w_head_opc;
    logic [OPERAND_W-1:0] w_head_opr;

    logic [INSTR_W-1:0]   r_mem [DEPTH];
    logic [OPERAND_W-1:0] r_dataout;
    logic [OPCODE_W-1:0]  r_instruction;
    logic                 r_valid;

    ir_queue_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .consume     (consume),
        .flush       (flush),
        .push_ok     (w_push),
        .pop_ok      (w_pop),
        .full        (full),
        .empty       (w_empty),
        .rd_ptr      (w_rd_ptr),
        .wr_ptr      (w_wr_ptr),
        .rd_ptr_next (w_rd_ptr_next),
        .count       (count),
        .count_next  (w_count_next)
    );

`ifdef IR_PARITY_EN
    logic r_par_err;

    assign w_data = datain[INSTR_W-1:0];

    // Even parity: any odd reduction over data+parity is a mismatch.
    always_ff @(posedge clk) begin
        if (rst || flush)            r_par_err <= 1'b0;
        else if (w_push && ^datain)  r_par_err <= 1'b1;
    end

    assign par_err = r_par_err;
`else
    assign w_data  = datain;
    assign par_err = 1'b0;
`endif

    // Increment only applies to a resident head that is not leaving this cycle.
    assign w_inc    = inc_en && r_valid && !w_pop && !flush;
    // The next head is the word being written when nothing else remains.
    assign w_bypass = w_push && (w_wr_ptr == w_rd_ptr_next);

    always_comb begin
        w_head = r_mem[w_rd_ptr_next];
        if (w_bypass) w_head = w_data;
        w_head_opc = w_head[INSTR_W-1 -: OPCODE_W];
        w_head_opr = w_head[OPERAND_W-1:0];
        if (w_inc) w_head_opr = r_dataout + OPERAND_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_ptr] <= w_data;
        if (w_inc)  r_mem[w_rd_ptr] <= {r_instruction, w_head_opr};
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (w_count_next == '0)) begin
            r_dataout     <= '0;
            r_instruction <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_dataout     <= w_head_opr;
            r_instruction <= w_head_opc;
            r_valid       <= 1'b1;
        end
    end

    assign dataout     = r_dataout;
    assign instruction = r_instruction;
    assign valid       = r_valid;

endmodule

`default_nettype wire

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the instruction register: a DEPTH-entry instruction prefetch queue between program memory and the control unit.
- Fetched words are split into an opcode field and an operand field.
- The head entry drives the control unit and bus; its operand can be incremented in place for multi-word and indirect sequences.
- Supports decoder-driven pop, branch flush, and back-pressure to the fetch logic.

Parameters:
- INSTR_W, 18, width of a fetched instruction word.
- OPCODE_W, 6, upper field width, bits [INSTR_W-1 : INSTR_W-OPCODE_W].
- OPERAND_W, 12, lower field width, bits [OPERAND_W-1:0]; OPCODE_W+OPERAND_W must equal INSTR_W (elaboration error otherwise).
- DEPTH, 2, queue entries, power of two, minimum 1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- write_en, input, 1, push datain; ignored when full and no pop in the same cycle.
- datain, input, INSTR_W (INSTR_W+1 with IR_PARITY_EN), fetched word.
- consume, input, 1, decoder pops head; ignored when empty.
- inc_en, input, 1, increment head operand.
- flush, input, 1, discard all entries (branch taken).
- dataout, output, OPERAND_W, head operand to bus.
- instruction, output, OPCODE_W, head opcode.
- valid, output, 1, head entry present.
- full, output, 1, count == DEPTH.
- count, output, $clog2(DEPTH+1), occupancy.
- par_err, output, 1, parity error flag (IR_PARITY_EN only; otherwise tied 0).

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset and flush state: on rst, all outputs go to 0 (dataout, instruction, valid, full, count, par_err) and the read/write pointers clear. rst mid-operation discards every entry in the same edge.
- Output registers: all outputs are registered. When valid=0, dataout and instruction hold 0, never stale data.
- Push latency: a word pushed into an empty queue appears on dataout/instruction with valid=1 one cycle after the write_en edge.
- Pop: consume with valid=1 advances the head. The next entry is visible the following cycle; if none remains, valid=0 and the outputs are 0.
- Simultaneous push and pop: write_en and consume together are legal at any occupancy, including full. count is unchanged, and the pushed word lands behind the remaining entries. At DEPTH=1, the pushed word becomes head next cycle.
- Push while full without pop: write dropped, no state change. The fetch logic must honour full.
- Pop while empty: ignored, count stays 0.
- inc_en:
  - With valid=1 and consume=0: head operand <= operand+1 mod 2^OPERAND_W (0xFFF -> 0x000). Opcode unchanged.
  - With consume=1: pop wins and the increment is dropped.
  - With valid=0: ignored.
- Priority: rst > flush > {consume, write_en, inc_en}.
  - flush clears all entries and count; a write_en in the same cycle is discarded.
- Counters: pointers wrap modulo DEPTH. count saturates structurally; it never exceeds DEPTH and never underflows.
- State: storage array plus rd_ptr, wr_ptr and count. No further FSM states beyond occupancy.

Optional Feature:
- IR_PARITY_EN defined:
  - datain gains a MSB even-parity bit over the INSTR_W data bits.
  - A mismatch on a push sets par_err on the next edge. par_err is sticky until rst or flush.
  - The erroneous word is still enqueued.
- IR_PARITY_EN undefined: datain is exactly INSTR_W bits; par_err is tied to 0; no parity logic.

Decomposition:
- Package ir_pkg: default width constants (INSTR_W_DEF=18, OPCODE_W_DEF=6, OPERAND_W_DEF=12), opcode_t typedef, operand_t typedef, and a function split_instr returning {opcode, operand}.
- One sub-module, ir_queue_ctrl: pointer/count management producing push_ok, pop_ok, full and empty. The top module owns storage, the increment and parity.

Test Plan:
- Reset then push 0x2_5A3C (opcode 0x25, operand 0xA3C) -> after 1 cycle valid=1, instruction=0x25, dataout=0xA3C, count=1.
- DEPTH=2: push 0x01001, 0x02002, 0x03003 with no pop -> full=1, count=2, third word dropped; two pops return 0x001 then 0x002, then valid=0 and dataout=0.
- Head operand 0xFFF, inc_en for 1 cycle -> dataout=0x000, instruction unchanged. inc_en together with consume -> popped, next entry's operand is not incremented.
- Full queue with write_en=1 and consume=1 for 4 cycles -> count stays 2, words emerge in push order.
- Queue with 2 entries, flush with write_en=1 in the same cycle -> next cycle valid=0, count=0, written word absent. rst mid-stream gives the same result.
- IR_PARITY_EN: push a word with a wrong parity bit -> par_err=1 next cycle and remains 1 through a good push, clearing on flush.
